// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART receive framing logic: command codes,
// FSM state encoding and the saturating error-counter helper.
package uart_frame_pkg;

    localparam logic [7:0] CMD_OPERAND  = 8'h4E;
    localparam logic [7:0] CMD_OPERATOR = 8'h4F;
    localparam logic [7:0] CMD_RESULT   = 8'h3D;

    localparam int ERR_COUNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PAYLOAD = 2'b01,
        ST_COMMIT  = 2'b10
    } rx_frame_state_t;

    function automatic logic [ERR_COUNT_W-1:0] err_sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (v == {ERR_COUNT_W{1'b1}}) ? v : v + ERR_COUNT_W'(1);
    endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the allowed gap is used up.
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry acts on the edge that completes TIMEOUT_CYCLES cycles of silence.
    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Receive-side framer: turns the UART byte stream into operand/operator
// words with enter strobes and result-request triggers for the RPN ALU.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_ready,
    input  logic [7:0]             rx_data,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_is_op,
    output logic                   enter,
    output logic                   trigger,
    output logic [ERR_COUNT_W-1:0] err_count,
    output logic [3:0]             status
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] NB_CNT  = CNT_W'(NB);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    rx_frame_state_t        state_q, state_d;
    logic                   rx_ready_q;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic                   is_op_q, is_op_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   data_is_op_q, data_is_op_d;
    logic                   enter_q, enter_d;
    logic                   trigger_q, trigger_d;
    logic [ERR_COUNT_W-1:0] err_q, err_d;
    logic                   timeout_seen_q, timeout_seen_d;
    logic                   badcmd_seen_q, badcmd_seen_d;

    logic                   accept;
    logic                   tmr_clear;
    logic                   tmr_enable;
    logic                   tmr_expired;
    logic [CNT_W-1:0]       need;
    logic [7:0]             op_byte;
    logic [DATA_WIDTH-1:0]  shift_ins;

    assign accept     = rx_ready && !rx_ready_q;
    assign tmr_enable = (state_q == ST_PAYLOAD);
    assign tmr_clear  = accept || (state_q != ST_PAYLOAD);
    assign need       = is_op_q ? ONE_CNT : NB_CNT;

    // The single operator byte sits at whichever end the shift direction fills.
    assign op_byte   = MSB_FIRST ? shift_q[7:0] : shift_q[DATA_WIDTH-1 -: 8];
    assign shift_ins = MSB_FIRST ? ((shift_q << 8) | DATA_WIDTH'(rx_data))
                                 : ((shift_q >> 8) | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 8)));

    frame_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        is_op_d        = is_op_q;
        shift_d        = shift_q;
        data_out_d     = data_out_q;
        data_is_op_d   = data_is_op_q;
        enter_d        = 1'b0;
        trigger_d      = 1'b0;
        err_d          = err_q;
        timeout_seen_d = timeout_seen_q;
        badcmd_seen_d  = badcmd_seen_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (rx_data)
                        CMD_OPERAND, CMD_OPERATOR: begin
                            state_d    = ST_PAYLOAD;
                            byte_cnt_d = '0;
                            is_op_d    = (rx_data == CMD_OPERATOR);
                            shift_d    = '0;
                        end
                        CMD_RESULT: trigger_d = 1'b1;
                        default: begin
                            badcmd_seen_d = 1'b1;
                            err_d         = err_sat_inc(err_q);
                        end
                    endcase
                end
            end
            ST_PAYLOAD: begin
                // A full count is checked first so the commit follows from registered state.
                if (byte_cnt_q == need) begin
                    state_d = ST_COMMIT;
                end else if (accept) begin
                    shift_d    = shift_ins;
                    byte_cnt_d = byte_cnt_q + ONE_CNT;
                end else if (tmr_expired) begin
                    state_d        = ST_IDLE;
                    timeout_seen_d = 1'b1;
                    err_d          = err_sat_inc(err_q);
                end
            end
            ST_COMMIT: begin
                data_out_d   = is_op_q ? DATA_WIDTH'(op_byte) : shift_q;
                data_is_op_d = is_op_q;
                enter_d      = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            rx_ready_q     <= 1'b0;
            byte_cnt_q     <= '0;
            is_op_q        <= 1'b0;
            shift_q        <= '0;
            data_out_q     <= '0;
            data_is_op_q   <= 1'b0;
            enter_q        <= 1'b0;
            trigger_q      <= 1'b0;
            err_q          <= '0;
            timeout_seen_q <= 1'b0;
            badcmd_seen_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_ready_q     <= rx_ready;
            byte_cnt_q     <= byte_cnt_d;
            is_op_q        <= is_op_d;
            shift_q        <= shift_d;
            data_out_q     <= data_out_d;
            data_is_op_q   <= data_is_op_d;
            enter_q        <= enter_d;
            trigger_q      <= trigger_d;
            err_q          <= err_d;
            timeout_seen_q <= timeout_seen_d;
            badcmd_seen_q  <= badcmd_seen_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_is_op = data_is_op_q;
    assign enter      = enter_q;
    assign trigger    = trigger_q;
    assign err_count  = err_q;
    assign status     = {timeout_seen_q, badcmd_seen_q, state_q};

endmodule
